// File: rtl/alu_pkg.sv
// Shared opcode encoding and default width for the registered ALU.
package alu_pkg;

    localparam int ALU_WIDTH = 8;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_MUL  = 4'h2,
        ALU_DIV  = 4'h3,
        ALU_SHL  = 4'h4,
        ALU_SHR  = 4'h5,
        ALU_ROL  = 4'h6,
        ALU_ROR  = 4'h7,
        ALU_AND  = 4'h8,
        ALU_OR   = 4'h9,
        ALU_XOR  = 4'hA,
        ALU_NOR  = 4'hB,
        ALU_NAND = 4'hC,
        ALU_XNOR = 4'hD,
        ALU_GT   = 4'hE,
        ALU_EQ   = 4'hF
    } alu_op_e;

endpackage

// File: rtl/alu_if.sv
// Operand/result bundle for the ALU. No handshake: the master presents a new
// operation every cycle and the result appears one rising edge later.
interface alu_if import alu_pkg::*; #(
    parameter int WIDTH = ALU_WIDTH
) ();

    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       ALU_Sel;
    logic [WIDTH-1:0] ALU_Out;
    logic             CarryOut;

    modport master (
        output A,
        output B,
        output ALU_Sel,
        input  ALU_Out,
        input  CarryOut
    );

    modport slave (
        input  A,
        input  B,
        input  ALU_Sel,
        output ALU_Out,
        output CarryOut
    );

endinterface

// File: rtl/alu_core.sv
// Combinational op decode and datapath; produces the next result and carry.
module alu_core import alu_pkg::*; #(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       sel,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] prod_lo;
    logic [WIDTH-1:0] quot;
    alu_op_e          op;

    assign op      = alu_op_e'(sel);
    assign sum     = {1'b0, a} + {1'b0, b};
    assign diff    = a - b;
    assign prod_lo = a * b;
    // Division by zero saturates to all ones instead of producing X.
    assign quot    = (b == '0) ? '1 : a / b;

    // Carry always reflects the plain add, independent of the selected op.
    assign carry = sum[WIDTH];

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:  result = sum[WIDTH-1:0];
            ALU_SUB:  result = diff;
            ALU_MUL:  result = prod_lo;
            ALU_DIV:  result = quot;
            ALU_SHL:  result = {a[WIDTH-2:0], 1'b0};
            ALU_SHR:  result = {1'b0, a[WIDTH-1:1]};
            ALU_ROL:  result = {a[WIDTH-2:0], a[WIDTH-1]};
            ALU_ROR:  result = {a[0], a[WIDTH-1:1]};
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_NOR:  result = ~(a | b);
            ALU_NAND: result = ~(a & b);
            ALU_XNOR: result = ~(a ^ b);
            ALU_GT:   result = {{(WIDTH-1){1'b0}}, (a > b)};
            ALU_EQ:   result = {{(WIDTH-1){1'b0}}, (a == b)};
        endcase
    end

endmodule

// File: rtl/alu.sv
// Registered ALU top: one-cycle latency, synchronous active-high reset.
module alu import alu_pkg::*; #(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic  clk,
    input  logic  rst,
    alu_if.slave  bus
);

    logic [WIDTH-1:0] next_result;
    logic             next_carry;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .a      (bus.A),
        .b      (bus.B),
        .sel    (bus.ALU_Sel),
        .result (next_result),
        .carry  (next_carry)
    );

    // Reset wins over the operation presented in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.ALU_Out  <= '0;
            bus.CarryOut <= 1'b0;
        end else begin
            bus.ALU_Out  <= next_result;
            bus.CarryOut <= next_carry;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Directed and randomized checks of the registered ALU against an arithmetic model.
module tb_alu;

    logic clk = 1'b0;
    logic rst;
    int   compared = 0;
    int   mismatched = 0;

    alu_if #(.WIDTH(8)) bus ();

    alu #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference computed with plain integer arithmetic on 0..255 values.
    function automatic void ref_model(input int a, input int b, input int sel,
                                      output int res, output int cy);
        case (sel)
            0:  res = (a + b) % 256;
            1:  res = (a - b + 256) % 256;
            2:  res = (a * b) % 256;
            3:  res = (b == 0) ? 255 : a / b;
            4:  res = (a * 2) % 256;
            5:  res = a / 2;
            6:  res = (a * 2) % 256 + a / 128;
            7:  res = a / 2 + (a % 2) * 128;
            8:  res = a & b;
            9:  res = a | b;
            10: res = a ^ b;
            11: res = 255 - (a | b);
            12: res = 255 - (a & b);
            13: res = 255 - (a ^ b);
            14: res = (a > b) ? 1 : 0;
            default: res = (a == b) ? 1 : 0;
        endcase
        cy = (a + b > 255) ? 1 : 0;
    endfunction

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
        bus.A       = a;
        bus.B       = b;
        bus.ALU_Sel = sel;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s out: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_cy(input string tag, input logic obs, input logic exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s carry: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    logic [7:0] sweep_exp [16];
    logic [7:0] ra, rb;
    logic [3:0] rs;
    int         res, cy;

    initial begin
        sweep_exp = '{8'h0C, 8'h08, 8'h14, 8'h05, 8'h14, 8'h05, 8'h14, 8'h05,
                      8'h02, 8'h0A, 8'h08, 8'hF5, 8'hFD, 8'hF7, 8'h01, 8'h00};

        rst = 1'b1;
        drive(8'hFF, 8'hFF, 4'h0);
        repeat (2) begin
            tick();
            check_out("reset", bus.ALU_Out, 8'h00);
            check_cy("reset", bus.CarryOut, 1'b0);
        end
        rst = 1'b0;
        tick();
        check_out("post_reset_add", bus.ALU_Out, 8'hFE);
        check_cy("post_reset_add", bus.CarryOut, 1'b1);

        for (int k = 1; k <= 16; k++) begin
            drive(8'h0A, 8'h02, 4'(k % 16));
            tick();
            check_out($sformatf("sweep_op%0d", k % 16), bus.ALU_Out, sweep_exp[k % 16]);
            check_cy($sformatf("sweep_op%0d", k % 16), bus.CarryOut, 1'b0);
            repeat (9) tick();
            check_out($sformatf("sweep_hold_op%0d", k % 16), bus.ALU_Out, sweep_exp[k % 16]);
        end

        drive(8'hF6, 8'h0A, 4'h0);
        tick();
        check_out("wrap_add", bus.ALU_Out, 8'h00);
        check_cy("wrap_add", bus.CarryOut, 1'b1);
        drive(8'hF6, 8'h0A, 4'h1);
        tick();
        check_out("wrap_sub", bus.ALU_Out, 8'hEC);
        check_cy("wrap_sub", bus.CarryOut, 1'b1);

        drive(8'h81, 8'h00, 4'h4); tick(); check_out("edge_shl", bus.ALU_Out, 8'h02);
        drive(8'h81, 8'h00, 4'h5); tick(); check_out("edge_shr", bus.ALU_Out, 8'h40);
        drive(8'h81, 8'h00, 4'h6); tick(); check_out("edge_rol", bus.ALU_Out, 8'h03);
        drive(8'h81, 8'h00, 4'h7); tick(); check_out("edge_ror", bus.ALU_Out, 8'hC0);
        check_cy("edge_ror", bus.CarryOut, 1'b0);

        drive(8'h37, 8'h00, 4'h3); tick(); check_out("div_zero", bus.ALU_Out, 8'hFF);
        drive(8'h55, 8'h55, 4'hF); tick(); check_out("eq_equal", bus.ALU_Out, 8'h01);
        drive(8'h55, 8'h55, 4'hE); tick(); check_out("gt_equal", bus.ALU_Out, 8'h00);
        drive(8'h10, 8'h20, 4'h2); tick(); check_out("mul_wrap", bus.ALU_Out, 8'h00);
        check_cy("mul_wrap", bus.CarryOut, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rs = 4'($urandom_range(0, 15));
            drive(ra, rb, rs);
            if (i == 500) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                check_out("mid_reset", bus.ALU_Out, 8'h00);
                check_cy("mid_reset", bus.CarryOut, 1'b0);
            end else begin
                tick();
                ref_model(int'(ra), int'(rb), int'(rs), res, cy);
                check_out($sformatf("rand%0d_op%0d", i, rs), bus.ALU_Out, 8'(res));
                check_cy($sformatf("rand%0d_op%0d", i, rs), bus.CarryOut, cy[0]);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
